// File: rtl/fp_int_mac_bit_serial_array.sv
// Multi-lane bit-serial FP16 x INT MAC: one broadcast activation, LANES serial weight streams.
// Define FP_INT_MAC_SAT_EN to saturate lane accumulators on signed overflow instead of wrapping.
module fp_int_mac_bit_serial_array #(
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10,
  parameter int ACC_WIDTH = 32,
  parameter int LANES     = 4,
  parameter int MAX_PREC  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           set,
  input  logic [EXP_WIDTH-1:0]           exp_set,
  input  logic [ACC_WIDTH-1:0]           fixed_point_acc,
  input  logic                           valid,
  input  logic [3:0]                     precision,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   act,
  input  logic [LANES-1:0]               w,
  output logic [EXP_WIDTH-1:0]           exp_out,
  output logic [LANES*ACC_WIDTH-1:0]     fixed_point_out,
  output logic                           busy,
  output logic                           done,
  output logic [LANES-1:0]               ovf
);

  localparam int ACT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int MANT_W    = MAN_WIDTH + 1;

  logic [EXP_WIDTH-1:0] exp_reg;
  logic [ACT_WIDTH-1:0] act_reg;
  logic [3:0]           prec_reg;
  logic [3:0]           cnt_reg;
  logic                 done_reg;
  logic [LANES-1:0]     ovf_reg;
  logic [ACC_WIDTH-1:0] acc_reg  [LANES];
  logic [ACC_WIDTH-1:0] acc_next [LANES];
  logic [LANES-1:0]     lane_ovf;

  logic                 first_bit;
  logic [ACT_WIDTH-1:0] act_cur;
  logic [3:0]           prec_cur;
  logic [3:0]           p_eff;
  logic                 act_sign;
  logic [EXP_WIDTH-1:0] act_exp;
  logic [MANT_W-1:0]    mant;
  logic [EXP_WIDTH:0]   d;
  logic                 d_neg;
  logic [ACC_WIDTH-1:0] mant_ext;
  logic [ACC_WIDTH-1:0] mag;
  logic [ACC_WIDTH-1:0] aligned;
  logic [ACC_WIDTH-1:0] term;
  logic                 last_bit;

  // On the first bit of a group the live bus is used; afterwards the latched copy,
  // so later bus activity cannot disturb the group in flight.
  always_comb begin
    first_bit = (cnt_reg == 4'd0);
    act_cur   = first_bit ? act : act_reg;
    prec_cur  = first_bit ? precision : prec_reg;
    if (prec_cur < 4'd2)
      p_eff = 4'd2;
    else if (32'(prec_cur) > MAX_PREC)
      p_eff = 4'(MAX_PREC);
    else
      p_eff = prec_cur;

    act_sign = act_cur[ACT_WIDTH-1];
    act_exp  = act_cur[ACT_WIDTH-2 -: EXP_WIDTH];
    mant     = {|act_exp, act_cur[MAN_WIDTH-1:0]};
    d        = {1'b0, exp_reg} - {1'b0, act_exp};
    d_neg    = d[EXP_WIDTH];
    mant_ext = {{(ACC_WIDTH-MANT_W){1'b0}}, mant};
    // Activation larger than the block exponent: keep it unshifted and flag it.
    if (d_neg)
      mag = mant_ext;
    else if (32'(d[EXP_WIDTH-1:0]) >= ACC_WIDTH)
      mag = '0;
    else
      mag = mant_ext >> d[EXP_WIDTH-1:0];
    aligned  = act_sign ? -mag : mag;
    term     = aligned << cnt_reg;
    last_bit = (cnt_reg == p_eff - 4'd1);
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ACC_WIDTH:0] acc_ext;
    logic [ACC_WIDTH:0] term_ext;
    logic [ACC_WIDTH:0] sum_ext;

    // One guard bit: it holds the true sign, so a mismatch with the MSB is overflow.
    assign acc_ext      = {acc_reg[gi][ACC_WIDTH-1], acc_reg[gi]};
    assign term_ext     = {term[ACC_WIDTH-1], term};
    assign sum_ext      = last_bit ? (acc_ext - term_ext) : (acc_ext + term_ext);
    assign lane_ovf[gi] = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
`ifdef FP_INT_MAC_SAT_EN
    assign acc_next[gi] = !lane_ovf[gi]     ? sum_ext[ACC_WIDTH-1:0] :
                          sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                               {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    assign acc_next[gi] = sum_ext[ACC_WIDTH-1:0];
`endif
    assign fixed_point_out[gi*ACC_WIDTH +: ACC_WIDTH] = acc_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_reg  <= '0;
      act_reg  <= '0;
      prec_reg <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
      ovf_reg  <= '0;
      for (int i = 0; i < LANES; i++) acc_reg[i] <= '0;
    end else if (set) begin
      exp_reg  <= exp_set;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
      ovf_reg  <= '0;
      for (int i = 0; i < LANES; i++) acc_reg[i] <= fixed_point_acc;
    end else begin
      done_reg <= 1'b0;
      if (valid) begin
        if (first_bit) begin
          act_reg  <= act;
          prec_reg <= precision;
        end
        for (int i = 0; i < LANES; i++) begin
          if (w[i]) acc_reg[i] <= acc_next[i];
        end
        ovf_reg  <= ovf_reg | (w & lane_ovf) | {LANES{first_bit & d_neg}};
        cnt_reg  <= last_bit ? 4'd0 : cnt_reg + 4'd1;
        done_reg <= last_bit;
      end
    end
  end

  assign exp_out = exp_reg;
  assign busy    = (cnt_reg != 4'd0);
  assign done    = done_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_fp_int_mac_bit_serial_array.sv
// Scoreboard bench: stimulus pushes expected lane sums, a monitor pops them on each done pulse.
module tb_fp_int_mac_bit_serial_array;
  localparam int EW = 5;
  localparam int MW = 10;
  localparam int AW = 32;
  localparam int L  = 4;
  localparam int MP = 8;
  localparam int OW = L * AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          set = 1'b0;
  logic [EW-1:0] exp_set = '0;
  logic [AW-1:0] fixed_point_acc = '0;
  logic          valid = 1'b0;
  logic [3:0]    precision = '0;
  logic [15:0]   act = '0;
  logic [L-1:0]  w = '0;
  logic [EW-1:0] exp_out;
  logic [OW-1:0] fixed_point_out;
  logic          busy;
  logic          done;
  logic [L-1:0]  ovf;

  fp_int_mac_bit_serial_array #(
    .EXP_WIDTH(EW), .MAN_WIDTH(MW), .ACC_WIDTH(AW), .LANES(L), .MAX_PREC(MP)
  ) dut (
    .clk(clk), .rst(rst), .set(set), .exp_set(exp_set),
    .fixed_point_acc(fixed_point_acc), .valid(valid), .precision(precision),
    .act(act), .w(w), .exp_out(exp_out), .fixed_point_out(fixed_point_out),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string         name;
    logic [OW-1:0] lanes;
    logic [L-1:0]  ovf;
  } exp_t;
  exp_t exp_q[$];

`ifdef FP_INT_MAC_SAT_EN
  localparam logic [AW-1:0] OVF_LANE0 = 32'h7FFFFFFF;
`else
  localparam logic [AW-1:0] OVF_LANE0 = 32'h80001BF0;
`endif

  function automatic logic [OW-1:0] pack4(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 required no done, lanes %h", fixed_point_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_lanes"}, fixed_point_out, e.lanes);
        check({e.name, "_ovf"}, OW'(ovf), OW'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [EW-1:0] e, input logic [AW-1:0] a);
    set = 1'b1; exp_set = e; fixed_point_acc = a;
    valid = 1'b1; w = '1;  // must be ignored while set is high
    tick();
    set = 1'b0; valid = 1'b0; w = '0;
  endtask

  task automatic send_bit(input logic [L-1:0] wv);
    valid = 1'b1; w = wv;
    tick();
    valid = 1'b0; w = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    check("reset_lanes", fixed_point_out, '0);
    check("reset_exp", OW'(exp_out), '0);
    check("reset_flags", OW'({busy, done, ovf}), '0);
    rst = 1'b1;
    tick();

    // Basic and signed weights: lane0=5, lane1=-5, lane2=-1, lane3=0 on 1.0
    do_set(5'd15, 32'd2);
    check("set_lanes", fixed_point_out, pack4(2, 2, 2, 2));
    check("set_exp", OW'(exp_out), OW'(15));
    act = 16'h3C00; precision = 4'd4;
    exp_q.push_back('{"basic", pack4(5122, -5118, -1022, 2), 4'b0000});
    send_bit(4'b0111);
    check("partial_sum", fixed_point_out, pack4(1026, 1026, 1026, 2));
    check("busy_mid", OW'(busy), OW'(1));
    send_bit(4'b0110);
    send_bit(4'b0101);
    send_bit(4'b0110);

    // 0.5 aligned to exponent 16 (a=256) with weight 3 at P=3, then -2.0 (a=-1024) weight 1 back-to-back
    do_set(5'd16, 32'd0);
    act = 16'h3800; precision = 4'd3;
    exp_q.push_back('{"align_half", pack4(768, 768, 768, 768), 4'b0000});
    exp_q.push_back('{"neg_act", pack4(-256, -256, -256, -256), 4'b0000});
    send_bit(4'b1111);
    send_bit(4'b1111);
    act = 16'hC000; precision = 4'd4;
    send_bit(4'b0000);
    send_bit(4'b1111);
    send_bit(4'b0000);
    send_bit(4'b0000);
    send_bit(4'b0000);

    // Pause three cycles mid-group while act/precision change on the bus
    do_set(5'd15, 32'd2);
    act = 16'h3C00; precision = 4'd4;
    exp_q.push_back('{"pause", pack4(5122, -5118, -1022, 2), 4'b0000});
    send_bit(4'b0111);
    send_bit(4'b0110);
    act = 16'h4000; precision = 4'd2;
    repeat (3) tick();
    check("pause_busy", OW'(busy), OW'(1));
    send_bit(4'b0101);
    send_bit(4'b0110);

    // Activation exponent 17 above block exponent 16: shift 0, all ovf set
    do_set(5'd16, 32'd0);
    act = 16'h4400; precision = 4'd2;
    exp_q.push_back('{"over_exp", pack4(1024, 0, 0, 0), 4'b1111});
    send_bit(4'b0001);
    send_bit(4'b0000);

    // Signed overflow on lane0: 0x7FFFFFF0 + 7*1024
    do_set(5'd15, 32'h7FFFFFF0);
    act = 16'h3C00; precision = 4'd4;
    exp_q.push_back('{"overflow", pack4(OVF_LANE0, 32'h7FFFFFF0, 32'h7FFFFFF0, 32'h7FFFFFF0), 4'b0001});
    send_bit(4'b0001);
    send_bit(4'b0001);
    send_bit(4'b0001);
    send_bit(4'b0000);

    // set aborts a group after two bits; next group restarts at bit 0
    do_set(5'd15, 32'd2);
    precision = 4'd4;
    send_bit(4'b0001);
    send_bit(4'b0001);
    do_set(5'd15, 32'd100);
    check("abort_lanes", fixed_point_out, pack4(100, 100, 100, 100));
    check("abort_busy", OW'(busy), OW'(0));
    precision = 4'd2;
    exp_q.push_back('{"after_abort", pack4(1124, 100, 100, 100), 4'b0000});
    send_bit(4'b0001);
    send_bit(4'b0000);
    // precision 1 clamps to 2: bits 0,1 -> -2 * 1024
    precision = 4'd1;
    exp_q.push_back('{"clamp_p", pack4(-924, 100, 100, 100), 4'b0000});
    send_bit(4'b0000);
    send_bit(4'b0001);

    // Reset in the middle of a group
    precision = 4'd4;
    send_bit(4'b1111);
    send_bit(4'b1111);
    rst = 1'b0;
    tick();
    check("rst_mid_lanes", fixed_point_out, '0);
    check("rst_mid_exp", OW'(exp_out), '0);
    check("rst_mid_flags", OW'({busy, done, ovf}), '0);
    rst = 1'b1;
    repeat (3) tick();

    check("pending_expect", OW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
